// File: rtl/tmds_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tmds_decoder
//  Description : Receive-side TMDS channel decoder. Accepts raw 10-bit words
//                from a deserialiser that may be misaligned to the symbol
//                boundary. Finds symbol alignment from runs of control tokens,
//                then decodes each aligned word to an 8-bit data byte or to a
//                2-bit control value.
//
//  Parameters  : TIMEOUT     - consecutive non-token words before a bit slip
//                              (while searching) or loss of lock (while
//                              locked); must exceed the longest active line
//                LOCK_TOKENS - consecutive tokens at one offset needed to
//                              declare lock (2..255)
//
//  Ports       : clk_pix     in   1   pixel clock, one TMDS word per cycle
//                rst_pix     in   1   synchronous reset, active high
//                tmds_in     in  10   raw word, bit 0 earliest on the wire
//                dout        out  8   decoded data byte (valid when de=1)
//                ctrl        out  2   decoded control {c1,c0} (de=0, locked=1)
//                de          out  1   1 = decoded word was a data symbol
//                locked      out  1   symbol alignment lock
//                slip_offset out  4   current bit offset, 0..9
//
//  Pipeline    : the previous raw word is held so that the aligned word can
//                straddle two raw words; the aligned word is registered
//                (stage 1) and the decode result is registered (stage 2).
//                Outputs are zero while unlocked; the pipeline keeps running.
//
//  Revision    : 1.0  initial release
// ============================================================================
module tmds_decoder #(
    parameter int TIMEOUT     = 4096,
    parameter int LOCK_TOKENS = 8
) (
    input  logic       clk_pix,
    input  logic       rst_pix,
    input  logic [9:0] tmds_in,
    output logic [7:0] dout,
    output logic [1:0] ctrl,
    output logic       de,
    output logic       locked,
    output logic [3:0] slip_offset
);

    localparam int                    c_IDLE_W    = $clog2(TIMEOUT);
    localparam logic [c_IDLE_W-1:0]   c_IDLE_LAST = c_IDLE_W'(TIMEOUT - 1);
    localparam logic [c_IDLE_W-1:0]   c_IDLE_ONE  = c_IDLE_W'(1);
    localparam logic [7:0]            c_LOCK_CNT  = 8'(LOCK_TOKENS);

    localparam logic [9:0] c_TOK_00 = 10'b1101010100;
    localparam logic [9:0] c_TOK_01 = 10'b0010101011;
    localparam logic [9:0] c_TOK_10 = 10'b0101010100;
    localparam logic [9:0] c_TOK_11 = 10'b1010101011;

    localparam logic [1:0] S_SEARCH = 2'd0;
    localparam logic [1:0] S_CHECK  = 2'd1;
    localparam logic [1:0] S_LOCKED = 2'd2;

    logic [9:0]          r_prev;
    logic [9:0]          r_w;
    logic [1:0]          r_state;
    logic [c_IDLE_W-1:0] r_idle;
    logic [7:0]          r_tcnt;
    logic [3:0]          r_offset;
    logic                r_locked;
    logic [7:0]          r_dout;
    logic [1:0]          r_ctrl;
    logic                r_de;

    logic [18:0]         w_window;
    logic [9:0]          w_aligned;
    logic                w_is_tok;
    logic [1:0]          w_tok_ctrl;
    logic [7:0]          w_qd;
    logic [7:0]          w_data;

    // Offset 9 reaches bit 18 at most, so tmds_in[9] only matters once it
    // has moved into r_prev.
    assign w_window = {tmds_in[8:0], r_prev};

    always_comb begin
        w_aligned = w_window[9:0];
        for (int k = 1; k < 10; k++) begin
            if (r_offset == 4'(k)) begin
                w_aligned = w_window[k +: 10];
            end
        end
    end

    always_comb begin
        w_is_tok   = 1'b1;
        w_tok_ctrl = 2'b00;
        case (r_w)
            c_TOK_00: w_tok_ctrl = 2'b00;
            c_TOK_01: w_tok_ctrl = 2'b01;
            c_TOK_10: w_tok_ctrl = 2'b10;
            c_TOK_11: w_tok_ctrl = 2'b11;
            default:  w_is_tok   = 1'b0;
        endcase
    end

    // Bit 9 flags an inverted payload, bit 8 selects XOR vs XNOR chaining.
    always_comb begin
        w_qd      = r_w[9] ? ~r_w[7:0] : r_w[7:0];
        w_data    = 8'd0;
        w_data[0] = w_qd[0];
        for (int i = 1; i < 8; i++) begin
            w_data[i] = r_w[8] ? (w_qd[i] ^ w_qd[i-1]) : ~(w_qd[i] ^ w_qd[i-1]);
        end
    end

    always_ff @(posedge clk_pix) begin
        if (rst_pix) begin
            r_prev   <= 10'd0;
            r_w      <= 10'd0;
            r_state  <= S_SEARCH;
            r_idle   <= '0;
            r_tcnt   <= 8'd0;
            r_offset <= 4'd0;
            r_locked <= 1'b0;
            r_dout   <= 8'd0;
            r_ctrl   <= 2'd0;
            r_de     <= 1'b0;
        end else begin
            r_prev <= tmds_in;
            r_w    <= w_aligned;
            r_de   <= ~w_is_tok;
            r_dout <= w_is_tok ? 8'd0 : w_data;
            r_ctrl <= w_is_tok ? w_tok_ctrl : 2'd0;

            case (r_state)
                S_SEARCH: begin
                    if (w_is_tok) begin
                        r_state <= S_CHECK;
                        r_tcnt  <= 8'd1;
                        r_idle  <= '0;
                    end else if (r_idle == c_IDLE_LAST) begin
                        r_idle   <= '0;
                        r_offset <= (r_offset == 4'd9) ? 4'd0 : r_offset + 4'd1;
                    end else begin
                        r_idle <= r_idle + c_IDLE_ONE;
                    end
                end
                S_CHECK: begin
                    if (w_is_tok) begin
                        r_tcnt <= r_tcnt + 8'd1;
                        if (r_tcnt + 8'd1 == c_LOCK_CNT) begin
                            r_state  <= S_LOCKED;
                            r_locked <= 1'b1;
                            r_idle   <= '0;
                        end
                    end else begin
                        // A broken run restarts the search at the same offset.
                        r_state <= S_SEARCH;
                        r_tcnt  <= 8'd0;
                        r_idle  <= '0;
                    end
                end
                S_LOCKED: begin
                    if (w_is_tok) begin
                        r_idle <= '0;
                    end else if (r_idle == c_IDLE_LAST) begin
                        // Offset is kept; a later search timeout slips it.
                        r_state  <= S_SEARCH;
                        r_locked <= 1'b0;
                        r_idle   <= '0;
                        r_tcnt   <= 8'd0;
                    end else begin
                        r_idle <= r_idle + c_IDLE_ONE;
                    end
                end
                default: begin
                    r_state  <= S_SEARCH;
                    r_locked <= 1'b0;
                    r_idle   <= '0;
                    r_tcnt   <= 8'd0;
                end
            endcase
        end
    end

    // r_locked and the stage-2 registers update on the same edge, so this
    // gate never exposes a decode from the wrong lock state.
    assign dout        = r_locked ? r_dout : 8'd0;
    assign ctrl        = r_locked ? r_ctrl : 2'd0;
    assign de          = r_locked & r_de;
    assign locked      = r_locked;
    assign slip_offset = r_offset;

endmodule
`default_nettype wire

// File: tb/tb_tmds_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_tmds_decoder
//  Description : Self-checking bench for tmds_decoder. A bit-level stream of
//                encoded symbols (optionally rotated) drives the decoder; a
//                reference model built from run/gap counting and a plain
//                TMDS decode predicts every output on every cycle, and
//                scenario checks confirm lock, slip, timeout and reset.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_tmds_decoder;

    localparam int TIMEOUT = 64;
    localparam int LOCK    = 8;

    logic       clk_pix = 1'b0;
    logic       rst_pix = 1'b1;
    logic [9:0] tmds_in = 10'd0;
    logic [7:0] dout;
    logic [1:0] ctrl;
    logic       de;
    logic       locked;
    logic [3:0] slip_offset;

    always #5 clk_pix = ~clk_pix;

    tmds_decoder #(
        .TIMEOUT     (TIMEOUT),
        .LOCK_TOKENS (LOCK)
    ) u_dut (
        .clk_pix     (clk_pix),
        .rst_pix     (rst_pix),
        .tmds_in     (tmds_in),
        .dout        (dout),
        .ctrl        (ctrl),
        .de          (de),
        .locked      (locked),
        .slip_offset (slip_offset)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [9:0] tok_tab [4] = '{10'b1101010100, 10'b0010101011,
                                 10'b0101010100, 10'b1010101011};

    function automatic int tok_index(input logic [9:0] w);
        for (int i = 0; i < 4; i++) if (w == tok_tab[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] tmds_dec(input logic [9:0] w);
        logic [7:0] q, d;
        q    = w[9] ? ~w[7:0] : w[7:0];
        d[0] = q[0];
        for (int i = 1; i < 8; i++) d[i] = q[i] ^ q[i-1] ^ ~w[8];
        return d;
    endfunction

    // Transition-minimising encoder; the inversion choice is free here since
    // the decoder honours bit 9 either way.
    function automatic logic [9:0] tmds_enc(input logic [7:0] d, input bit inv);
        logic [8:0] q;
        int  ones;
        bit  use_xnor;
        ones     = $countones(d);
        use_xnor = (ones > 4) || (ones == 4 && d[0] == 1'b0);
        q[0]     = d[0];
        for (int i = 1; i < 8; i++) q[i] = use_xnor ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = ~use_xnor;
        return {inv, q[8], inv ? ~q[7:0] : q[7:0]};
    endfunction

    // Reference model state
    logic [9:0] m_prev, m_w;
    bit         m_locked;
    int         m_run, m_gap, m_off;
    logic [7:0] e_dout;
    logic [1:0] e_ctrl;
    logic       e_de;

    logic       obs_locked [$];
    logic       obs_de     [$];
    logic [7:0] obs_dout   [$];
    logic [1:0] obs_ctrl   [$];

    bit         bitq [$];
    bit         cap_en = 1'b0;
    logic [7:0] cap_q [$];

    task automatic model_tick(input logic [9:0] word, input bit rst);
        int          t;
        bit          tok;
        int          off_used;
        logic [19:0] win;
        if (rst) begin
            m_prev = '0; m_w = '0; m_locked = 0; m_run = 0; m_gap = 0; m_off = 0;
            e_dout = '0; e_ctrl = '0; e_de = 1'b0;
            return;
        end
        t        = tok_index(m_w);
        tok      = (t >= 0);
        off_used = m_off;
        if (!m_locked) begin
            if (tok) begin
                m_run++;
                m_gap = 0;
                if (m_run == LOCK) m_locked = 1;
            end else if (m_run > 0) begin
                m_run = 0;
                m_gap = 0;
            end else if (m_gap == TIMEOUT - 1) begin
                m_off = (m_off + 1) % 10;
                m_gap = 0;
            end else begin
                m_gap++;
            end
        end else begin
            if (tok) m_gap = 0;
            else if (m_gap == TIMEOUT - 1) begin
                m_locked = 0; m_gap = 0; m_run = 0;
            end else m_gap++;
        end
        e_de   = m_locked && !tok;
        e_dout = e_de ? tmds_dec(m_w) : 8'd0;
        e_ctrl = (m_locked && tok) ? t[1:0] : 2'd0;
        win    = {word, m_prev};
        m_w    = win[off_used +: 10];
        m_prev = word;
    endtask

    task automatic step(input logic [9:0] word, input bit rst);
        tmds_in = word;
        rst_pix = rst;
        @(posedge clk_pix);
        model_tick(word, rst);
        @(negedge clk_pix);
        check_val("cycle", {16'd0, locked, slip_offset, de, ctrl, dout},
                  {16'd0, m_locked, 4'(m_off), e_de, e_ctrl, e_dout});
        obs_locked.push_back(locked);
        obs_de.push_back(de);
        obs_dout.push_back(dout);
        obs_ctrl.push_back(ctrl);
        if (cap_en && de) cap_q.push_back(dout);
    endtask

    task automatic send_sym(input logic [9:0] sym);
        for (int i = 0; i < 10; i++) bitq.push_back(sym[i]);
        while (bitq.size() >= 10) begin
            logic [9:0] wd;
            for (int i = 0; i < 10; i++) wd[i] = bitq.pop_front();
            step(wd, 1'b0);
        end
    endtask

    task automatic send_tok(input int c);
        send_sym(tok_tab[c]);
    endtask

    task automatic send_data(input logic [7:0] b);
        send_sym(tmds_enc(b, bit'($urandom_range(0, 1))));
    endtask

    task automatic start_scenario(input int rot);
        step(10'd0, 1'b1);
        bitq.delete();
        for (int i = 0; i < rot; i++) bitq.push_back(1'b0);
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int n8, na5, n0, n63, n64, ntok, max_off;
        logic [7:0] sent [6];

        // Reset state
        start_scenario(0);
        check_val("rst_locked", locked, 0);
        check_val("rst_outs", {de, ctrl, dout, slip_offset}, 0);

        // 1: loopback at offset 0
        for (int i = 0; i < 20; i++) begin
            if (i == 7) n8 = obs_locked.size();
            send_tok(0);
        end
        check_val("s1_unlocked_before", obs_locked[n8+1], 0);
        check_val("s1_lock_8th", obs_locked[n8+2], 1);
        na5 = obs_locked.size();
        send_data(8'hA5); send_data(8'h00); send_data(8'hFF);
        for (int i = 0; i < 4; i++) send_tok(0);
        check_val("s1_de_a5", obs_de[na5+2], 1);
        check_val("s1_a5", obs_dout[na5+2], 8'hA5);
        check_val("s1_00", obs_dout[na5+3], 8'h00);
        check_val("s1_ff", obs_dout[na5+4], 8'hFF);
        check_val("s1_de_ff", obs_de[na5+4], 1);

        // 3: broken run, then full run
        start_scenario(0);
        for (int i = 0; i < 5; i++) send_tok(0);
        send_data(8'h3C);
        for (int i = 0; i < 8; i++) begin
            if (i == 7) n8 = obs_locked.size();
            send_tok(0);
        end
        for (int i = 0; i < 3; i++) send_tok(0);
        check_val("s3_not_yet", obs_locked[n8+1], 0);
        check_val("s3_lock", obs_locked[n8+2], 1);
        check_val("s3_offset", slip_offset, 0);

        // 4: idle timeout while locked
        for (int i = 0; i < 63; i++) begin
            if (i == 62) n63 = obs_locked.size();
            send_data(8'($urandom));
        end
        ntok = obs_locked.size();
        for (int i = 0; i < 4; i++) send_tok(0);
        check_val("s4_63_held", obs_locked[n63+2], 1);
        check_val("s4_tok_held", obs_locked[ntok+2], 1);
        for (int i = 0; i < 67; i++) begin
            if (i == 63) n64 = obs_locked.size();
            send_data(8'($urandom));
        end
        check_val("s4_64_still", obs_locked[n64+1], 1);
        check_val("s4_64_drop", obs_locked[n64+2], 0);
        check_val("s4_offset_kept", slip_offset, 0);

        // 5: all four control values while locked
        start_scenario(0);
        for (int i = 0; i < 10; i++) send_tok(0);
        n0 = obs_locked.size();
        for (int c = 0; c < 4; c++) send_tok(c);
        for (int i = 0; i < 3; i++) send_tok(0);
        for (int c = 0; c < 4; c++) begin
            check_val($sformatf("s5_ctrl%0d", c), obs_ctrl[n0+c+2], 32'(c));
            check_val($sformatf("s5_de%0d", c), {obs_locked[n0+c+2], obs_de[n0+c+2]}, 2'b10);
        end

        // 2: stream rotated by 7 bits
        start_scenario(7);
        max_off = 0;
        for (int win = 0; win < 40 && !locked; win++) begin
            for (int i = 0; i < 10; i++) send_tok(0);
            for (int i = 0; i < 54; i++) begin
                send_data(8'($urandom));
                if (int'(slip_offset) > max_off) max_off = int'(slip_offset);
            end
        end
        check_val("s2_locked", locked, 1);
        check_val("s2_offset", slip_offset, 7);
        check_val("s2_max_off", max_off, 7);
        for (int i = 0; i < 8; i++) send_tok(0);
        cap_q.delete();
        cap_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            sent[i] = 8'($urandom);
            send_data(sent[i]);
        end
        for (int i = 0; i < 4; i++) send_tok(1);
        cap_en = 1'b0;
        check_val("s2_cap_count", cap_q.size(), 6);
        for (int i = 0; i < 6 && i < cap_q.size(); i++)
            check_val($sformatf("s2_byte%0d", i), cap_q[i], sent[i]);

        // 6: reset while locked and streaming at offset 7
        for (int i = 0; i < 10; i++) send_data(8'($urandom));
        check_val("s6_pre_locked", locked, 1);
        step(tok_tab[0], 1'b1);
        check_val("s6_rst_locked", locked, 0);
        check_val("s6_rst_outs", {de, dout, slip_offset}, 0);
        bitq.delete();
        for (int i = 0; i < LOCK + 2 && !locked; i++) send_tok(0);
        check_val("s6_relock", locked, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
